// File: rtl/riscv_memory_hs_pkg.sv
// Shared encodings for the memory stage: funct3 load/store sizes, FSM states,
// default load timeout and the access-alignment helper.
package riscv_memory_hs_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_RSP = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

  // funct3[1:0] is log2 of the access size in bytes
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] low);
    case (f3[1:0])
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return |low;
    endcase
  endfunction

endpackage

// File: rtl/riscv_memory_hs_load_formatter.sv
// Load alignment: shift the bus word down to the addressed byte, then sign- or
// zero-extend according to funct3.
module riscv_memory_hs_load_formatter
  import riscv_memory_hs_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = XLEN'($signed(sh[7:0]));
      F3_H:    result = XLEN'($signed(sh[15:0]));
      F3_W:    result = XLEN'($signed(sh[31:0]));
      F3_BU:   result = XLEN'(sh[7:0]);
      F3_HU:   result = XLEN'(sh[15:0]);
      F3_WU:   result = XLEN'(sh[31:0]);
      F3_D:    result = sh;
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/riscv_memory_hs.sv
// Pipelined memory stage with a gnt/rvalid data-bus handshake, load timeout,
// misalignment detection and the MEM/WB pipeline register.
module riscv_memory_hs
  import riscv_memory_hs_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_m,
  input  logic              i_reg_write_m,
  input  logic              i_mem_read_m,
  input  logic              i_mem_write_m,
  input  logic [1:0]        i_result_src_m,
  input  logic [2:0]        i_funct3_m,
  input  logic [XLEN-1:0]   i_alu_result_m,
  input  logic [XLEN-1:0]   i_write_data_m,
  input  logic [XLEN-1:0]   i_pc_plus_4m,
  input  logic [XLEN-1:0]   i_ext_imm_m,
  input  logic [4:0]        i_rd_m,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_be,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [XLEN-1:0]   i_bus_rdata,
  output logic              o_stall_m,
  output logic              o_misalign,
  output logic              o_timeout,
  output logic [XLEN-1:0]   o_fault_addr,
  output logic              o_valid_w,
  output logic              o_reg_write_w,
  output logic [1:0]        o_result_src_w,
  output logic [XLEN-1:0]   o_alu_result_w,
  output logic [XLEN-1:0]   o_read_data_w,
  output logic [XLEN-1:0]   o_pc_plus_4w,
  output logic [XLEN-1:0]   o_ext_imm_w,
  output logic [4:0]        o_rd_w
);

  localparam int BEW  = XLEN/8;
  localparam int OFFW = $clog2(BEW);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] ext_imm;
    logic [4:0]      rd;
  } memwb_t;

  logic [0:0]      state, state_nxt;
  logic [7:0]      cnt;
  logic [OFFW-1:0] off;
  logic            mem_op, mis, is_st, in_idle, in_wait, to_hit, fault;
  logic [XLEN-1:0] ld_data;
  memwb_t          wb_d, wb_q;

  assign off     = i_alu_result_m[OFFW-1:0];
  assign mem_op  = i_valid_m & (i_mem_read_m | i_mem_write_m);
  assign is_st   = i_mem_write_m;
  assign in_idle = (state == ST_IDLE);
  assign in_wait = (state == ST_WAIT_RSP);
  assign mis     = mem_op & misaligned(i_funct3_m, i_alu_result_m[2:0]);
  // Response data arriving on the timeout cycle takes precedence
  assign to_hit  = in_wait & ~i_bus_rvalid & (cnt == 8'(TIMEOUT));
  assign fault   = (in_idle & mis) | to_hit;

  assign o_bus_req  = in_idle & mem_op & ~mis;
  assign o_bus_we   = o_bus_req & is_st;
  assign o_bus_addr = {i_alu_result_m[XLEN-1:OFFW], OFFW'(0)};
  assign o_stall_m  = in_wait ? ~(i_bus_rvalid | to_hit)
                              : (o_bus_req & ~(is_st & i_bus_gnt));

  always_comb begin
    o_bus_wdata = i_write_data_m;
    o_bus_be    = '1;
    case (i_funct3_m[1:0])
      2'd0: begin
        o_bus_wdata = {BEW{i_write_data_m[7:0]}};
        o_bus_be    = BEW'(1) << off;
      end
      2'd1: begin
        o_bus_wdata = {(XLEN/16){i_write_data_m[15:0]}};
        o_bus_be    = BEW'(3) << off;
      end
      2'd2: begin
        o_bus_wdata = {(XLEN/32){i_write_data_m[31:0]}};
        o_bus_be    = BEW'(15) << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (o_bus_req & ~is_st & i_bus_gnt) state_nxt = ST_WAIT_RSP;
      default: if (i_bus_rvalid | to_hit)          state_nxt = ST_IDLE;
    endcase
  end

  riscv_memory_hs_load_formatter #(.XLEN(XLEN), .OFFW(OFFW)) u_fmt (
    .rdata  (i_bus_rdata),
    .offset (off),
    .funct3 (i_funct3_m),
    .result (ld_data)
  );

  always_comb begin
    wb_d.valid      = i_valid_m & ~fault;
    wb_d.reg_write  = i_valid_m & i_reg_write_m & ~fault;
    wb_d.result_src = i_result_src_m;
    wb_d.alu_result = i_alu_result_m;
    wb_d.read_data  = ld_data;
    wb_d.pc_plus_4  = i_pc_plus_4m;
    wb_d.ext_imm    = i_ext_imm_m;
    wb_d.rd         = i_rd_m;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      o_misalign   <= 1'b0;
      o_timeout    <= 1'b0;
      o_fault_addr <= '0;
      wb_q         <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= in_idle ? 8'd0 : cnt + 8'd1;
      o_misalign <= in_idle & mis;
      o_timeout  <= to_hit;
      if (fault) o_fault_addr <= i_alu_result_m;
      if (o_stall_m) begin
        wb_q.valid     <= 1'b0;
        wb_q.reg_write <= 1'b0;
      end else begin
        wb_q <= wb_d;
      end
    end
  end

  assign o_valid_w      = wb_q.valid;
  assign o_reg_write_w  = wb_q.reg_write;
  assign o_result_src_w = wb_q.result_src;
  assign o_alu_result_w = wb_q.alu_result;
  assign o_read_data_w  = wb_q.read_data;
  assign o_pc_plus_4w   = wb_q.pc_plus_4;
  assign o_ext_imm_w    = wb_q.ext_imm;
  assign o_rd_w         = wb_q.rd;

endmodule

// File: tb/tb_riscv_memory_hs.sv
// Scoreboard bench: a 32-bit instance under randomized traffic with TIMEOUT=4,
// and a 64-bit instance for doubleword accesses and reset during a load.
module tb_riscv_memory_hs;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit instance
  logic        rst, valid_m, reg_write_m, mem_read_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_m, wd_m, pc4_m, imm_m;
  logic [4:0]  rd_m;
  logic        bus_req, bus_we, gnt, rvalid;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_be;
  logic        stall, misal, tout, valid_w, rw_w;
  logic [31:0] faddr, alu_w, rdd_w, pc4_w, imm_w;
  logic [1:0]  rs_w;
  logic [4:0]  rd_w;

  riscv_memory_hs #(.XLEN(32), .TIMEOUT(TO)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid_m(valid_m), .i_reg_write_m(reg_write_m),
    .i_mem_read_m(mem_read_m), .i_mem_write_m(mem_write_m), .i_result_src_m(result_src_m),
    .i_funct3_m(funct3_m), .i_alu_result_m(alu_m), .i_write_data_m(wd_m),
    .i_pc_plus_4m(pc4_m), .i_ext_imm_m(imm_m), .i_rd_m(rd_m),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_be(bus_be), .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata),
    .o_stall_m(stall), .o_misalign(misal), .o_timeout(tout), .o_fault_addr(faddr),
    .o_valid_w(valid_w), .o_reg_write_w(rw_w), .o_result_src_w(rs_w),
    .o_alu_result_w(alu_w), .o_read_data_w(rdd_w), .o_pc_plus_4w(pc4_w),
    .o_ext_imm_w(imm_w), .o_rd_w(rd_w)
  );

  // 64-bit instance
  logic        b_rst, b_valid_m, b_reg_write_m, b_mem_read_m, b_mem_write_m;
  logic [1:0]  b_result_src_m;
  logic [2:0]  b_funct3_m;
  logic [63:0] b_alu_m, b_wd_m, b_pc4_m, b_imm_m;
  logic [4:0]  b_rd_m;
  logic        b_bus_req, b_bus_we, b_gnt, b_rvalid;
  logic [63:0] b_bus_addr, b_bus_wdata, b_rdata;
  logic [7:0]  b_bus_be;
  logic        b_stall, b_misal, b_tout, b_valid_w, b_rw_w;
  logic [63:0] b_faddr, b_alu_w, b_rdd_w, b_pc4_w, b_imm_w;
  logic [1:0]  b_rs_w;
  logic [4:0]  b_rd_w;

  riscv_memory_hs #(.XLEN(64)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_valid_m(b_valid_m), .i_reg_write_m(b_reg_write_m),
    .i_mem_read_m(b_mem_read_m), .i_mem_write_m(b_mem_write_m), .i_result_src_m(b_result_src_m),
    .i_funct3_m(b_funct3_m), .i_alu_result_m(b_alu_m), .i_write_data_m(b_wd_m),
    .i_pc_plus_4m(b_pc4_m), .i_ext_imm_m(b_imm_m), .i_rd_m(b_rd_m),
    .o_bus_req(b_bus_req), .o_bus_we(b_bus_we), .o_bus_addr(b_bus_addr), .o_bus_wdata(b_bus_wdata),
    .o_bus_be(b_bus_be), .i_bus_gnt(b_gnt), .i_bus_rvalid(b_rvalid), .i_bus_rdata(b_rdata),
    .o_stall_m(b_stall), .o_misalign(b_misal), .o_timeout(b_tout), .o_fault_addr(b_faddr),
    .o_valid_w(b_valid_w), .o_reg_write_w(b_rw_w), .o_result_src_w(b_rs_w),
    .o_alu_result_w(b_alu_w), .o_read_data_w(b_rdd_w), .o_pc_plus_4w(b_pc4_w),
    .o_ext_imm_w(b_imm_w), .o_rd_w(b_rd_w)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu, rdd, pc4, imm;
    logic [4:0]  rd;
    bit          is_ld;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } bus_exp_t;

  typedef struct {
    bit          is_to;
    logic [31:0] addr;
  } flt_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  flt_exp_t flt_q[$];
  bit       mon_en = 1'b0;
  bit       exp_req = 1'b0, exp_stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got an event expected none", nm);
  endtask

  always @(negedge clk) begin : monitor
    wb_exp_t  w;
    bus_exp_t b;
    flt_exp_t f;
    if (mon_en) begin
      chk("stall", stall, exp_stall);
      chk("bus_req", bus_req, exp_req);
      if (bus_req && gnt) begin
        if (bus_q.size() == 0) unexpected("bus_handshake");
        else begin
          b = bus_q.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_we", bus_we, b.we);
          if (b.we) begin
            chk("bus_wdata", bus_wdata, b.wdata);
            chk("bus_be", bus_be, b.be);
          end
        end
      end
      if (valid_w) begin
        if (wb_q.size() == 0) unexpected("wb_valid");
        else begin
          w = wb_q.pop_front();
          chk("wb_reg_write", rw_w, w.rw);
          chk("wb_result_src", rs_w, w.rs);
          chk("wb_alu", alu_w, w.alu);
          chk("wb_pc4", pc4_w, w.pc4);
          chk("wb_imm", imm_w, w.imm);
          chk("wb_rd", rd_w, w.rd);
          if (w.is_ld) chk("wb_read_data", rdd_w, w.rdd);
        end
      end
      if (misal || tout) begin
        if (flt_q.size() == 0) unexpected("fault_pulse");
        else begin
          f = flt_q.pop_front();
          chk("fault_misalign", misal, !f.is_to);
          chk("fault_timeout", tout, f.is_to);
          chk("fault_addr", faddr, f.addr);
          chk("fault_bubble_valid", valid_w, 0);
          chk("fault_bubble_rw", rw_w, 0);
        end
      end
    end
  end

  // One instruction through MEM: drives EX/MEM fields and the bus responder,
  // and queues what the reference model says should come out.
  task automatic run_instr(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int gdly, input int rdly, input bit to);
    bit          mem, ms, ok, ld;
    int          n, off, sz;
    logic [31:0] sh, exp_rd;
    wb_exp_t     w;
    bus_exp_t    b;
    flt_exp_t    f;
    mem = v && (rd || wr);
    sz  = 1 << f3[1:0];
    ms  = mem && ((addr % sz) != 0);
    ok  = mem && !ms;
    ld  = ok && !wr;
    off = int'(addr % 4);
    if (!ok)     n = 1;
    else if (wr) n = gdly + 1;
    else if (to) n = gdly + TO + 2;
    else         n = gdly + rdly + 1;

    valid_m = v; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_m = addr; wd_m = wd;
    reg_write_m = 1'($urandom); result_src_m = 2'($urandom);
    pc4_m = $urandom; imm_m = $urandom; rd_m = 5'($urandom);

    sh = rdat >> (8 * off);
    case (f3)
      3'b000:  exp_rd = (sh & 32'hFF) - ((sh & 32'h80) << 1);
      3'b001:  exp_rd = (sh & 32'hFFFF) - ((sh & 32'h8000) << 1);
      3'b100:  exp_rd = sh & 32'hFF;
      3'b101:  exp_rd = sh & 32'hFFFF;
      default: exp_rd = sh;
    endcase

    if (ok) begin
      b.we   = wr;
      b.addr = addr & ~32'h3;
      case (f3[1:0])
        2'd0:    begin b.wdata = (wd & 32'hFF) * 32'h01010101;   b.be = 4'(1 << off); end
        2'd1:    begin b.wdata = (wd & 32'hFFFF) * 32'h00010001; b.be = 4'(3 << off); end
        default: begin b.wdata = wd;                             b.be = 4'hF;         end
      endcase
      bus_q.push_back(b);
    end
    if (v && !ms && !(ld && to)) begin
      w.rw = reg_write_m; w.rs = result_src_m; w.alu = addr; w.rdd = exp_rd;
      w.pc4 = pc4_m; w.imm = imm_m; w.rd = rd_m; w.is_ld = ld;
      wb_q.push_back(w);
    end
    if (ms || (ld && to)) begin
      f.is_to = !ms;
      f.addr  = addr;
      flt_q.push_back(f);
    end

    for (int c = 0; c < n; c++) begin
      exp_req   = ok && (c <= gdly);
      exp_stall = ok && (c < n - 1);
      gnt       = ok && (c == gdly);
      if (ld && c > gdly) rvalid = !to && (c == gdly + rdly);
      else                rvalid = 1'($urandom);
      rdata = (ld && c > gdly && rvalid) ? rdat : $urandom;
      @(posedge clk); #1;
    end
    gnt = 1'b0; rvalid = 1'b0;
  endtask

  initial begin : stim
    int          lf[5];
    int          kind;
    logic [2:0]  f3;
    lf = '{0, 1, 2, 4, 5};

    rst = 1'b1; b_rst = 1'b1;
    valid_m = 0; reg_write_m = 0; mem_read_m = 0; mem_write_m = 0; result_src_m = 0;
    funct3_m = 0; alu_m = 0; wd_m = 0; pc4_m = 0; imm_m = 0; rd_m = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    b_valid_m = 0; b_reg_write_m = 0; b_mem_read_m = 0; b_mem_write_m = 0; b_result_src_m = 0;
    b_funct3_m = 0; b_alu_m = 0; b_wd_m = 0; b_pc4_m = 0; b_imm_m = 0; b_rd_m = 0;
    b_gnt = 0; b_rvalid = 0; b_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_w", valid_w, 0);
    chk("rst_reg_write_w", rw_w, 0);
    chk("rst_result_src_w", rs_w, 0);
    chk("rst_alu_w", alu_w, 0);
    chk("rst_read_data_w", rdd_w, 0);
    chk("rst_pc4_w", pc4_w, 0);
    chk("rst_imm_w", imm_w, 0);
    chk("rst_rd_w", rd_w, 0);
    chk("rst_fault_addr", faddr, 0);
    chk("rst_misalign", misal, 0);
    chk("rst_timeout", tout, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_instr(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    run_instr(1, 0, 1, 3'b000, 32'h103, 32'h0000005A, 0, 2, 0, 0);
    run_instr(1, 1, 0, 3'b000, 32'h102, 0, 32'h0080FF00, 0, 4, 0);
    run_instr(1, 1, 0, 3'b100, 32'h102, 0, 32'h0080FF00, 1, 2, 0);
    run_instr(1, 1, 0, 3'b001, 32'h101, 0, 0, 0, 1, 0);
    run_instr(1, 1, 0, 3'b010, 32'h200, 0, 0, 0, 1, 1);
    // late response after the timeout must be ignored
    valid_m = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D; exp_req = 0; exp_stall = 0;
    @(posedge clk); #1;
    rvalid = 1'b0;
    run_instr(1, 1, 0, 3'b010, 32'h300, 0, 32'h12345678, 0, TO + 1, 0);
    run_instr(1, 0, 0, 3'b000, 32'h44, 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)
        run_instr(0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom & 32'h3FF, $urandom, 0, 0, 1, 0);
      else if (kind <= 2)
        run_instr(1, 0, 0, 3'($urandom), $urandom, $urandom, 0, 0, 1, 0);
      else if (kind <= 5)
        run_instr(1, 0, 1, 3'($urandom_range(0, 2)), $urandom & 32'h3FF, $urandom, 0,
                  $urandom_range(0, 3), 1, 0);
      else begin
        f3 = 3'(lf[$urandom_range(0, 4)]);
        run_instr(1, 1, 0, f3, $urandom & 32'h3FF, 0, $urandom, $urandom_range(0, 3),
                  $urandom_range(1, TO + 1), $urandom_range(0, 7) == 0);
      end
    end
    valid_m = 1'b0; exp_req = 0; exp_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("fault_queue_drained", flt_q.size(), 0);

    // 64-bit instance: LWU, SD, then reset in the middle of a load
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_valid_m = 1; b_mem_read_m = 1; b_mem_write_m = 0; b_funct3_m = 3'b110;
    b_alu_m = 64'h204; b_reg_write_m = 1; b_rd_m = 5'd7; b_gnt = 1;
    #1;
    chk("b_lwu_req", b_bus_req, 1);
    chk("b_lwu_addr", b_bus_addr, 64'h200);
    chk("b_lwu_stall_gnt", b_stall, 1);
    @(posedge clk); #1;
    b_gnt = 0; b_rvalid = 1; b_rdata = 64'h80000001_00000000;
    #1;
    chk("b_lwu_stall_rsp", b_stall, 0);
    @(posedge clk); #1;
    b_rvalid = 0;
    chk("b_lwu_valid_w", b_valid_w, 1);
    chk("b_lwu_data", b_rdd_w, 64'h00000000_80000001);
    chk("b_lwu_rd", b_rd_w, 7);

    b_mem_read_m = 0; b_mem_write_m = 1; b_funct3_m = 3'b011; b_alu_m = 64'h208;
    b_wd_m = 64'h01234567_89ABCDEF; b_gnt = 1;
    #1;
    chk("b_sd_be", b_bus_be, 8'hFF);
    chk("b_sd_wdata", b_bus_wdata, 64'h01234567_89ABCDEF);
    chk("b_sd_we", b_bus_we, 1);
    chk("b_sd_stall", b_stall, 0);
    @(posedge clk); #1;

    b_mem_read_m = 1; b_mem_write_m = 0; b_alu_m = 64'h210;
    @(posedge clk); #1;
    b_gnt = 0;
    chk("b_ld_wait_stall", b_stall, 1);
    chk("b_ld_wait_req", b_bus_req, 0);
    b_valid_m = 0; b_rst = 1;
    #1;
    chk("b_rst_valid_w", b_valid_w, 0);
    chk("b_rst_reg_write_w", b_rw_w, 0);
    chk("b_rst_alu_w", b_alu_w, 0);
    chk("b_rst_read_data_w", b_rdd_w, 0);
    chk("b_rst_rd_w", b_rd_w, 0);
    chk("b_rst_fault_addr", b_faddr, 0);
    chk("b_rst_timeout", b_tout, 0);
    chk("b_rst_stall", b_stall, 0);
    @(posedge clk); #1;
    b_rst = 0; b_rvalid = 1; b_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    b_rvalid = 0;
    chk("b_late_rvalid_ignored", b_valid_w, 0);
    b_valid_m = 1;
    #1;
    chk("b_idle_after_rst_req", b_bus_req, 1);
    chk("b_idle_after_rst_stall", b_stall, 1);
    @(posedge clk); #1;
    b_valid_m = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
